rr_op_arbiter: RTL and testbench

RR_OP_ARBITER -- requirements
Module: rr_op_arbiter

---
 rtl/rr_op_arbiter.sv | 81 ++++++++
 tb/tb_rr_op_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_op_arbiter.sv
// rr_op_arbiter: round-robin arbiter (descending, wrapping pointer) for a shared ALU; ports clk, rst (async), req[8], done -> grant[8] one-hot, op=7-k, valid/timeout pulses, busy
module rr_op_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] op,
  output logic       valid,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, k, idx, op_n;
  logic [7:0] cnt, cnt_n, grant_n;
  logic hit, valid_n, timeout_n;
  always_comb begin
    k = ptr;
    idx = ptr;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr - 3'(i);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        k = idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    op_n = op;
    ptr_n = ptr;
    cnt_n = cnt;
    valid_n = 1'b0;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (hit) begin
        state_n = GRANT;
        grant_n = 8'd1 << k;
        op_n = 3'd7 - k;
        ptr_n = k - 3'd1;
        cnt_n = 8'd0;
        valid_n = 1'b1;
      end
    end else if (done) begin
      state_n = IDLE;
      grant_n = 8'd0;
    end else if (state == WAIT && cnt == 8'(HOLD_MAX)) begin
      state_n = IDLE;
      grant_n = 8'd0;
      timeout_n = 1'b1;
    end else begin
      state_n = WAIT;
      cnt_n = cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 8'd0;
      op <= 3'd0;
      ptr <= 3'd7;
      cnt <= 8'd0;
      valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      op <= op_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      valid <= valid_n;
      timeout <= timeout_n;
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_rr_op_arbiter.sv
// tb_rr_op_arbiter: scoreboard bench for rr_op_arbiter
module tb_rr_op_arbiter;
  logic clk = 1'b0, rst = 1'b1, done = 1'b0;
  logic [7:0] req = 8'd0, grant;
  logic [2:0] op;
  logic valid, busy, timeout;
  logic [10:0] exp_q[$];
  logic [10:0] e;
  int n_vec = 0, n_err = 0;

  rr_op_arbiter #(.HOLD_MAX(15)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .op(op), .valid(valid), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] o);
    exp_q.push_back({g, o});
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!valid) chk("valid_wait", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'd0;
    done = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_op", op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot0", 32'($onehot0(grant)), 1);
      if (valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("grant", grant, e[10:3]);
          chk("op", op, e[2:0]);
          chk("busy_on_valid", busy, 1);
        end
      end
    end
  end

  initial begin
    do_reset();
    // full rotation 7..0 then wrap to 7
    for (int i = 0; i < 9; i++) push(8'd1 << (7 - (i % 8)), 3'(i % 8));
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_valid();
      @(posedge clk); #1 done = 1'b1;
      if (i == 8) req = 8'd0;
      @(posedge clk); #1 done = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);

    // two requesters alternate, done after two WAIT cycles
    do_reset();
    push(8'h04, 3'd5); push(8'h01, 3'd7); push(8'h04, 3'd5);
    req = 8'b0000_0101;
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      @(posedge clk);
      @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("wait_valid_low", valid, 0);
      @(posedge clk); #1 done = 1'b1;
      if (i == 2) req = 8'd0;
      @(posedge clk); #1 done = 1'b0;
    end
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", busy, 0);

    // HOLD_MAX expiry and regrant
    do_reset();
    push(8'h08, 3'd4); push(8'h08, 3'd4);
    req = 8'h08;
    wait_valid();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("hold_grant", grant, 8'h08);
      chk("hold_no_timeout", timeout, 0);
    end
    @(negedge clk);
    chk("timeout_pulse", timeout, 1);
    chk("timeout_grant", grant, 0);
    chk("timeout_busy", busy, 0);
    @(negedge clk);
    chk("regrant_valid", valid, 1);
    chk("timeout_one_cycle", timeout, 0);
    req = 8'd0;
    done = 1'b1;
    @(posedge clk); #1 done = 1'b0;

    // asynchronous reset mid-WAIT
    do_reset();
    push(8'h80, 3'd0); push(8'h40, 3'd1); push(8'h20, 3'd2);
    req = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      wait_valid();
      @(posedge clk); #1 done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
    end
    wait_valid();
    @(posedge clk);
    #3;
    chk("pre_rst_grant", grant, 8'h20);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    push(8'h80, 3'd0);
    wait_valid();
    @(posedge clk); #1 done = 1'b1; req = 8'd0;
    @(posedge clk); #1 done = 1'b0;

    // no preemption when req drops; done during GRANT skips WAIT
    do_reset();
    push(8'h08, 3'd4);
    req = 8'h08;
    wait_valid();
    @(posedge clk); #1 req = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_grant", grant, 8'h08);
      chk("held_busy", busy, 1);
    end
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    chk("release_grant", grant, 0);
    chk("release_busy", busy, 0);
    push(8'h02, 3'd6);
    req = 8'h02;
    wait_valid();
    done = 1'b1;
    @(posedge clk); #1 done = 1'b0; req = 8'd0;
    @(negedge clk);
    chk("grant_done_busy", busy, 0);
    chk("grant_done_grant", grant, 0);
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
